// File: rtl/scan_ctrl10.sv
// scan_ctrl10 -- multiplexed 10-digit display scan controller.
//
// A prescaler divides the clock into digit slots of DIV cycles. Each slot
// drives one active-low digit enable, after BLANK blanked cycles that let the
// previous digit's segments discharge (ghosting suppression). The number of
// digits per frame is sampled from ndig only when the scan wraps to digit 0,
// so a frame is never cut short or stretched by a mid-frame change.
//
// Timing model: every register updates on the rising edge. dig, slot and
// frame are computed from the next-state values of cnt/sel, so in any cycle
// they describe the cnt/sel values held in that same cycle (no pipeline lag).
// The en input is sampled at each edge; the cycle after an edge with en=0
// shows dig all ones and no pulses.
//
// Handshake: there is no valid/ready interface. slot and frame are
// single-cycle, registered, strobe-style outputs with no back-pressure.

module scan_ctrl10 #(
  parameter int DIV   = 1000,
  parameter int BLANK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] ndig,
  output logic [3:0] sel,
  output logic [9:0] dig,
  output logic       slot,
  output logic       frame
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [3:0]    ND_MAX   = 4'd10;

  // Stored digit count: 0 and anything above 10 mean "all ten digits".
  function automatic logic [3:0] nd_map(input logic [3:0] n);
    logic [3:0] r;
    r = n;
    if ((n == 4'd0) || (n > ND_MAX)) begin
      r = ND_MAX;
    end
    return r;
  endfunction

  // State registers and their next-state values.
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    sel_q, sel_d;
  logic [3:0]    nd_q,  nd_d;
  logic [9:0]    dig_q, dig_d;
  logic          slot_q, slot_d;
  logic          frame_q, frame_d;

  // Decoded events for this cycle.
  logic cnt_last;
  logic advance;
  logic wrap;
  logic active_d;

  // Slot/frame event decode from the current state.
  always_comb begin
    cnt_last = (cnt_q == CNT_LAST);
    advance  = en && cnt_last;
    // >= rather than == keeps the scan inside the frame even if sel_q were
    // ever found beyond the last digit.
    wrap     = advance && (sel_q >= (nd_q - 4'd1));
  end

  // Next-state logic for the prescaler, digit index and digit count.
  always_comb begin
    cnt_d = cnt_q;
    sel_d = sel_q;
    nd_d  = nd_q;
    if (en) begin
      if (cnt_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (advance) begin
      if (wrap) begin
        sel_d = 4'd0;
        nd_d  = nd_map(ndig);
      end else begin
        sel_d = sel_q + 4'd1;
      end
    end
  end

  // Output next-state: decode the enable for the cnt/sel values being loaded.
  always_comb begin
    active_d = en && (int'(cnt_d) >= BLANK);
    dig_d    = '1;
    for (int k = 0; k < 10; k++) begin
      if (active_d && (sel_d == 4'(k))) begin
        dig_d[k] = 1'b0;
      end
    end
    slot_d  = advance;
    frame_d = wrap;
  end

  // All state, cleared asynchronously so reset discards any partial slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      sel_q   <= 4'd0;
      nd_q    <= ND_MAX;
      dig_q   <= '1;
      slot_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      nd_q    <= nd_d;
      dig_q   <= dig_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
    end
  end

  assign sel   = sel_q;
  assign dig   = dig_q;
  assign slot  = slot_q;
  assign frame = frame_q;

`ifndef SYNTHESIS
  // Digit index stays inside the current frame and the physical digit range.
  a_sel_range: assert property (@(posedge clk) disable iff (rst)
    (sel_q < nd_q) && (sel_q <= 4'd9));

  // Stored digit count is always 1..10.
  a_nd_range: assert property (@(posedge clk) disable iff (rst)
    (nd_q >= 4'd1) && (nd_q <= ND_MAX));

  // Never more than one digit driven at once.
  a_dig_onehot: assert property (@(posedge clk) disable iff (rst)
    $countones(~dig_q) <= 1);

  // A frame pulse is always also a slot pulse.
  a_frame_slot: assert property (@(posedge clk) disable iff (rst)
    frame_q |-> slot_q);

  // Prescaler never leaves 0..DIV-1.
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= CNT_LAST);
`endif

endmodule

// File: tb/tb_scan_ctrl10.sv
// Bench for scan_ctrl10: two instances share all inputs, one with BLANK=2
// and one with BLANK=0, both with DIV=8. A slot/frame model built from
// modular arithmetic predicts the outputs after every rising edge; directed
// literal checks pin the model at hand-computed points.

module tb_scan_ctrl10;

  localparam int DIV     = 8;
  localparam int BLANK_A = 2;
  localparam int BLANK_B = 0;

  // Clock / reset / inputs
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] ndig;

  logic [3:0] sel_a, sel_b;
  logic [9:0] dig_a, dig_b;
  logic       slot_a, slot_b, frame_a, frame_b;

  int checks   = 0;
  int failures = 0;
  int t        = 0;   // enabled edges since the last reset release

  always #5 clk = ~clk;

  scan_ctrl10 #(.DIV(DIV), .BLANK(BLANK_A)) u_a (
    .clk(clk), .rst(rst), .en(en), .ndig(ndig),
    .sel(sel_a), .dig(dig_a), .slot(slot_a), .frame(frame_a)
  );

  scan_ctrl10 #(.DIV(DIV), .BLANK(BLANK_B)) u_b (
    .clk(clk), .rst(rst), .en(en), .ndig(ndig),
    .sel(sel_b), .dig(dig_b), .slot(slot_b), .frame(frame_b)
  );

  // Behavioural model: position inside the slot, digit, frame length.
  typedef struct {
    int         cnt;
    int         sel;
    int         nd;
    logic [9:0] dig;
    bit         slot;
    bit         frame;
  } m_t;

  function automatic m_t m_reset();
    m_t m;
    m.cnt = 0; m.sel = 0; m.nd = 10;
    m.dig = 10'h3FF; m.slot = 1'b0; m.frame = 1'b0;
    return m;
  endfunction

  function automatic m_t m_step(m_t m, bit e, int nd_in, int blank);
    bit boundary;
    m.slot  = 1'b0;
    m.frame = 1'b0;
    m.dig   = 10'h3FF;
    if (!e) return m;
    boundary = (m.cnt == DIV - 1);
    m.cnt = (m.cnt + 1) % DIV;
    if (boundary) begin
      m.sel  = (m.sel + 1) % m.nd;
      m.slot = 1'b1;
      if (m.sel == 0) begin
        m.frame = 1'b1;
        m.nd = (nd_in == 0 || nd_in > 10) ? 10 : nd_in;
      end
    end
    if (m.cnt >= blank) m.dig = ~(10'b1 << m.sel);
    return m;
  endfunction

  m_t ma = m_reset();
  m_t mb = m_reset();

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("m_sel_a",   sel_a,   ma.sel);
    chk("m_dig_a",   dig_a,   ma.dig);
    chk("m_slot_a",  slot_a,  ma.slot);
    chk("m_frame_a", frame_a, ma.frame);
    chk("m_sel_b",   sel_b,   mb.sel);
    chk("m_dig_b",   dig_b,   mb.dig);
    chk("m_slot_b",  slot_b,  mb.slot);
    chk("m_frame_b", frame_b, mb.frame);
    chk("onehot_a",  int'($countones(~dig_a) <= 1), 1);
    chk("sel_max_a", int'(sel_a <= 4'd9), 1);
  endtask

  // Scoreboard: advance the model on every edge and compare just after it.
  always @(posedge clk) begin
    bit   e_s, r_s;
    int   n_s;
    e_s = en; r_s = rst; n_s = int'(ndig);
    #1;
    if (r_s) begin
      ma = m_reset();
      mb = m_reset();
    end else begin
      ma = m_step(ma, e_s, n_s, BLANK_A);
      mb = m_step(mb, e_s, n_s, BLANK_B);
    end
    cmp_all();
  end

  // Asynchronous reset must act without waiting for a clock edge.
  always @(posedge rst) begin
    ma = m_reset();
    mb = m_reset();
    #1;
    cmp_all();
  end

  // Driver tasks: inputs change on the falling edge only.
  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (en && !rst) t++;
    end
  endtask

  task automatic goto(input int target);
    if (target < t) begin
      chk("goto_order", t, target);
    end else begin
      adv(target - t);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ndig = 4'd10;
    repeat (2) @(negedge clk);
    chk("rst_sel",   sel_a,   0);
    chk("rst_dig",   dig_a,   10'h3FF);
    chk("rst_slot",  slot_a,  0);
    chk("rst_frame", frame_a, 0);
    rst = 1'b0;
    @(negedge clk);
    en = 1'b1; t = 0;

    // Basic scan, ten digits.
    adv(1);
    chk("blank_a_e1", dig_a, 10'h3FF);
    chk("noblank_b_e1", dig_b, 10'h3FE);
    adv(1);
    chk("lat_a_e2", dig_a, 10'h3FE);
    goto(8);
    chk("slot1_sel", sel_a, 1);
    chk("slot1_pulse", slot_a, 1);
    chk("slot1_noframe", frame_a, 0);
    goto(80);
    chk("frame1_pulse", frame_a, 1);
    chk("frame1_sel", sel_a, 0);

    // Short frame requested mid-frame.
    goto(120);
    chk("short_sel5", sel_a, 5);
    ndig = 4'd3;
    goto(152);
    chk("short_reach9", sel_a, 9);
    goto(160);
    chk("short_wrap", frame_a, 1);
    goto(176);
    chk("short_sel2", sel_a, 2);
    goto(184);
    chk("short_frame24", frame_a, 1);

    // Illegal counts behave as ten digits.
    ndig = 4'd0;
    goto(208);
    chk("ill0_wrap", frame_a, 1);
    ndig = 4'd13;
    goto(280);
    chk("ill0_sel9", sel_a, 9);
    goto(288);
    chk("ill0_frame80", frame_a, 1);
    goto(360);
    chk("ill13_sel9", sel_a, 9);
    goto(368);
    chk("ill13_frame80", frame_a, 1);

    // Enable gap at sel=2, cnt=4.
    goto(388);
    chk("gap_pre_sel", sel_a, 2);
    en = 1'b0;
    adv(1);
    chk("gap_dig", dig_a, 10'h3FF);
    chk("gap_sel", sel_a, 2);
    adv(4);
    chk("gap_end_sel", sel_a, 2);
    en = 1'b1;
    adv(3);
    chk("resume3_sel", sel_a, 2);
    adv(1);
    chk("resume4_sel", sel_a, 3);
    chk("resume4_slot", slot_a, 1);

    // Asynchronous reset at sel=7, cnt=5.
    goto(429);
    chk("pre_rst_sel", sel_a, 7);
    ndig = 4'd1;
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", sel_a, 0);
    chk("arst_dig", dig_a, 10'h3FF);
    chk("arst_slot", slot_a, 0);
    chk("arst_frame", frame_a, 0);
    @(negedge clk);
    rst = 1'b0; t = 0;

    // First frame after reset is ten digits, then single digit.
    goto(72);
    chk("post_rst_sel9", sel_a, 9);
    goto(80);
    chk("post_rst_frame", frame_a, 1);
    goto(85);
    chk("nd1_dig_b", dig_b, 10'h3FE);
    chk("nd1_sel_b", sel_b, 0);
    goto(88);
    chk("nd1_slot_b", slot_b, 1);
    chk("nd1_frame_b", frame_b, 1);
    adv(1);
    chk("nd1_slot_b_off", slot_b, 0);
    chk("nd1_dig_b_cnt1", dig_b, 10'h3FE);
    goto(96);
    chk("nd1_frame_b_2", frame_b, 1);
    chk("nd1_sel_a", sel_a, 0);

    adv(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/scan_ctrl10.md
SCAN_CTRL10 -- requirements
Module: scan_ctrl10

Interface
REQ-001 Parameter DIV, default 1000: clock cycles per digit slot; legal range DIV >= 2.
REQ-002 Parameter BLANK, default 4: blanked cycles at the start of each slot; legal range 0 <= BLANK < DIV.
REQ-003 Port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port en, input, 1 bit: scan enable.
REQ-006 Port ndig, input, 4 bits: number of active digits in each frame.
REQ-007 Port sel, output, 4 bits: digit index for the 10-way display data mux; sel[3:0] maps to s3..s0.
REQ-008 Port dig, output, 10 bits: digit enables, one-hot, active-low; bit k drives digit k.
REQ-009 Port slot, output, 1 bit: one-cycle pulse each time sel advances.
REQ-010 Port frame, output, 1 bit: one-cycle pulse each time sel wraps to 0.

Function
REQ-011 An internal prescaler cnt SHALL count 0..DIV-1 while en=1, wrapping to 0 after DIV-1.
REQ-012 On a cycle where en=1 and cnt=DIV-1, sel SHALL advance: sel+1, or 0 if sel = nd_q-1.
REQ-013 nd_q SHALL be a registered copy of ndig, where values 0 and 11..15 are stored as 10.
REQ-014 nd_q SHALL load only on a wrap edge (sel goes to 0) or during reset; ndig changes mid-frame SHALL NOT take effect until the next frame.
REQ-015 sel SHALL never exceed nd_q-1 and SHALL never exceed 9.
REQ-016 dig SHALL be registered and SHALL match the cnt and sel values of the same cycle (no lag):
- all ones when en=0 or cnt < BLANK;
- otherwise dig[sel]=0 and all other bits 1.
REQ-017 At most one bit of dig SHALL be 0 in any cycle.
REQ-018 slot SHALL be 1 in the cycle where sel first holds its new value after any advance, including a wrap; otherwise 0.
REQ-019 frame SHALL be 1 in the same cycle as slot when the new sel is 0; otherwise 0.
REQ-020 While en=0, cnt, sel and nd_q SHALL hold, and slot and frame SHALL be 0.
REQ-021 When en rises, counting SHALL resume from the held cnt; there is no restart of the slot.
REQ-022 With nd_q=1, sel SHALL stay 0, and frame and slot SHALL pulse together every DIV enabled cycles.
REQ-023 Latency from the first en=1 cycle after reset to the first dig activity SHALL be BLANK cycles.

Reset
REQ-024 Asserting rst SHALL immediately force: cnt=0, sel=0, nd_q=10, dig=10'b1111111111, slot=0, frame=0.
REQ-025 Reset asserted mid-slot or mid-frame SHALL discard all progress, with no partial pulses.
REQ-026 After rst falls, the first enabled clock edge SHALL start cnt at 0→1 within slot 0.

Verification (DIV=8, BLANK=2 unless stated)
REQ-027 Basic scan: rst pulse, then en=1, ndig=10.
- sel steps 0..9 every 8 cycles.
- dig goes low at the 3rd cycle of each slot for 6 cycles.
- frame pulses once per 80 cycles, when sel=0.
REQ-028 Short frame: ndig=3 applied mid-frame while sel=5.
- sel continues to 9 and wraps to 0.
- The following frame runs 0,1,2,0 and frame pulses every 24 cycles.
REQ-029 Illegal count: ndig=0, then ndig=13.
- Both behave as 10 digits.
- sel never shows 10..15.
REQ-030 Enable gap: en=0 for 5 cycles starting at cnt=4, sel=2.
- dig is all ones during the gap, and sel and cnt hold.
- After en returns, sel advances 4 enabled cycles later.
REQ-031 Async reset: rst asserted mid-cycle at sel=7, cnt=5.
- Outputs go to reset values before the next clock edge.
- nd_q returns to 10.
REQ-032 BLANK=0, ndig=1.
- dig=10'b1111111110 continuously while en=1.
- slot and frame pulse together every 8 cycles.
